// File: rtl/mem_arbiter.sv
// Two-port to single-RAM arbiter: an instruction-fetch port and a data port share
// one 32-bit synchronous RAM, with data priority bounded by a starvation counter.
module mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,

    input  logic              If_Req,
    input  logic [31:0]       If_Addr,
    output logic              If_Gnt,
    output logic              If_Valid,
    output logic [31:0]       If_Rdata,

    input  logic              D_Req,
    input  logic              D_We,
    input  logic              D_Byte,
    input  logic [31:0]       D_Addr,
    input  logic [31:0]       D_Wdata,
    output logic              D_Gnt,
    output logic              D_Valid,
    output logic [31:0]       D_Rdata,
    output logic              D_Err,

    output logic              Ram_En,
    output logic [3:0]        Ram_We,
    output logic [ADDR_W-1:0] Ram_Addr,
    output logic [31:0]       Ram_Wdata,
    input  logic [31:0]       Ram_Rdata
);

    localparam int               CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            r_State;
    state_t            w_NextState;

    logic              r_SelD;
    logic              r_We;
    logic              r_Byte;
    logic [ADDR_W+1:0] r_Addr;
    logic [31:0]       r_Wdata;
    logic [31:0]       r_RdWord;
    logic [CNT_W-1:0]  r_Starve;

    logic              r_IfValid;
    logic              r_DValid;
    logic              r_DErr;
    logic [31:0]       r_IfRdata;
    logic [31:0]       r_DRdata;

    logic              w_Arbitrate;
    logic              w_GrantD;
    logic              w_Misalign;
    logic              w_Issue;
    logic              w_DoRam;
    logic              w_DoStore;
    logic [3:0]        w_ByteSel;
    logic [7:0]        w_Lane;
    logic [31:0]       w_LoadData;
    logic              w_unusedBits;

    // Requests are only looked at in IDLE, so at most one access is ever in flight.
    assign w_Arbitrate = (r_State == IDLE) && (If_Req || D_Req);
    assign w_GrantD    = D_Req && !(If_Req && (r_Starve == STARVE_LIM));

    assign w_Misalign  = r_SelD && !r_Byte && (r_Addr[1:0] != 2'b00);
    assign w_Issue     = (r_State == ISSUE);
    assign w_DoRam     = w_Issue && !w_Misalign;
    assign w_DoStore   = w_DoRam && r_We;
    assign w_ByteSel   = 4'b0001 << r_Addr[1:0];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_State <= IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    always_comb begin
        w_NextState = r_State;
        case (r_State)
            IDLE:    if (If_Req || D_Req) w_NextState = ISSUE;
            ISSUE:   w_NextState = (w_Misalign || r_We) ? RESP : WAIT;
            WAIT:    w_NextState = RESP;
            RESP:    w_NextState = IDLE;
            default: w_NextState = IDLE;
        endcase
    end

    // The fetch path is always a word load, so its low address bits are forced to zero.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_SelD  <= 1'b0;
            r_We    <= 1'b0;
            r_Byte  <= 1'b0;
            r_Addr  <= '0;
            r_Wdata <= '0;
        end else if (w_Arbitrate) begin
            r_SelD <= w_GrantD;
            if (w_GrantD) begin
                r_We    <= D_We;
                r_Byte  <= D_Byte;
                r_Addr  <= D_Addr[ADDR_W+1:0];
                r_Wdata <= D_Wdata;
            end else begin
                r_We    <= 1'b0;
                r_Byte  <= 1'b0;
                r_Addr  <= {If_Addr[ADDR_W+1:2], 2'b00};
                r_Wdata <= '0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_Starve <= '0;
        end else if (w_Arbitrate) begin
            if (!If_Req || !w_GrantD) begin
                r_Starve <= '0;
            end else begin
                r_Starve <= r_Starve + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_RdWord <= '0;
        end else if (r_State == WAIT) begin
            r_RdWord <= Ram_Rdata;
        end
    end

    always_comb begin
        w_Lane = r_RdWord[7:0];
        case (r_Addr[1:0])
            2'd0:    w_Lane = r_RdWord[7:0];
            2'd1:    w_Lane = r_RdWord[15:8];
            2'd2:    w_Lane = r_RdWord[23:16];
            default: w_Lane = r_RdWord[31:24];
        endcase
    end

    assign w_LoadData = r_Byte ? {24'h000000, w_Lane} : r_RdWord;

    // Valid is registered on the way out of RESP; a misaligned access leaves D_Rdata alone.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_IfValid <= 1'b0;
            r_DValid  <= 1'b0;
            r_DErr    <= 1'b0;
            r_IfRdata <= '0;
            r_DRdata  <= '0;
        end else begin
            r_IfValid <= (r_State == RESP) && !r_SelD;
            r_DValid  <= (r_State == RESP) && r_SelD;
            r_DErr    <= (r_State == RESP) && w_Misalign;
            if ((r_State == RESP) && !r_SelD) begin
                r_IfRdata <= r_RdWord;
            end
            if ((r_State == RESP) && r_SelD && !r_We && !w_Misalign) begin
                r_DRdata <= w_LoadData;
            end
        end
    end

    assign If_Gnt    = w_Issue && !r_SelD;
    assign D_Gnt     = w_Issue && r_SelD;
    assign If_Valid  = r_IfValid;
    assign D_Valid   = r_DValid;
    assign D_Err     = r_DErr;
    assign If_Rdata  = r_IfRdata;
    assign D_Rdata   = r_DRdata;

    // RAM strobes decode straight from the state, so an async reset drops them at once.
    assign Ram_En    = w_DoRam;
    assign Ram_We    = w_DoStore ? (r_Byte ? w_ByteSel : 4'b1111) : 4'b0000;
    assign Ram_Addr  = w_Issue ? r_Addr[ADDR_W+1:2] : '0;
    assign Ram_Wdata = w_DoStore ? (r_Byte ? {4{r_Wdata[7:0]}} : r_Wdata) : '0;

    assign w_unusedBits = &{1'b0, If_Addr[31:ADDR_W+2], If_Addr[1:0], D_Addr[31:ADDR_W+2]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural RAM, a reference memory model and
// a scoreboard queue of expected responses checked with immediate assertions.
module tb_mem_arbiter;

    localparam int ADDR_W     = 10;
    localparam int STARVE_MAX = 2;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              Clk;
    logic              Reset_n;
    logic              If_Req;
    logic [31:0]       If_Addr;
    logic              If_Gnt;
    logic              If_Valid;
    logic [31:0]       If_Rdata;
    logic              D_Req;
    logic              D_We;
    logic              D_Byte;
    logic [31:0]       D_Addr;
    logic [31:0]       D_Wdata;
    logic              D_Gnt;
    logic              D_Valid;
    logic [31:0]       D_Rdata;
    logic              D_Err;
    logic              Ram_En;
    logic [3:0]        Ram_We;
    logic [ADDR_W-1:0] Ram_Addr;
    logic [31:0]       Ram_Wdata;
    logic [31:0]       Ram_Rdata;

    typedef struct {
        bit          isD;
        logic [31:0] data;
        bit          err;
        int          lat;
    } exp_t;

    exp_t        sbQueue[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] lastD      = '0;
    logic [31:0] lastIf     = '0;
    logic [31:0] modelMem [0:DEPTH-1];

    bit   [31:0] ramDelta [0:DEPTH-1];
    logic [31:0] ramPat;
    logic [31:0] ramWord;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .If_Req   (If_Req),
        .If_Addr  (If_Addr),
        .If_Gnt   (If_Gnt),
        .If_Valid (If_Valid),
        .If_Rdata (If_Rdata),
        .D_Req    (D_Req),
        .D_We     (D_We),
        .D_Byte   (D_Byte),
        .D_Addr   (D_Addr),
        .D_Wdata  (D_Wdata),
        .D_Gnt    (D_Gnt),
        .D_Valid  (D_Valid),
        .D_Rdata  (D_Rdata),
        .D_Err    (D_Err),
        .Ram_En   (Ram_En),
        .Ram_We   (Ram_We),
        .Ram_Addr (Ram_Addr),
        .Ram_Wdata(Ram_Wdata),
        .Ram_Rdata(Ram_Rdata)
    );

    function automatic logic [31:0] memPattern(input int idx);
        return 32'hC0DE0000 | 32'(idx);
    endfunction

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Synchronous RAM with one-cycle read latency; contents held as a delta from the pattern.
    always @(posedge Clk) begin
        if (Ram_En) begin
            ramPat  = memPattern(int'(Ram_Addr));
            ramWord = ramDelta[Ram_Addr] ^ ramPat;
            Ram_Rdata <= ramWord;
            for (int b = 0; b < 4; b++) begin
                if (Ram_We[b]) ramWord[8*b +: 8] = Ram_Wdata[8*b +: 8];
            end
            ramDelta[Ram_Addr] <= ramWord ^ ramPat;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic predict(input bit isD, input bit we, input bit isByte,
                           input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
        int          w;
        int          sh;
        logic [31:0] word;
        w     = int'(addr[ADDR_W+1:2]);
        sh    = 8 * int'(addr[1:0]);
        e.isD = isD;
        e.err = 1'b0;
        if (isD && !isByte && (addr[1:0] != 2'b00)) begin
            e.err  = 1'b1;
            e.data = lastD;
            e.lat  = 2;
        end else if (isD && we) begin
            if (isByte) modelMem[w][sh +: 8] = wdata[7:0];
            else        modelMem[w] = wdata;
            e.data = lastD;
            e.lat  = 2;
        end else begin
            word  = modelMem[w];
            e.lat = 3;
            if (isD && isByte) e.data = {24'h000000, word[sh +: 8]};
            else               e.data = word;
        end
    endtask

    task automatic applyStimulus(input bit isD, input bit we, input bit isByte,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic [3:0]  expWe;
        logic [31:0] expWdata;
        bit          misalign;
        misalign = isD && !isByte && (addr[1:0] != 2'b00);
        if (!isD || !we || misalign) expWe = 4'b0000;
        else if (isByte)             expWe = 4'b0001 << addr[1:0];
        else                         expWe = 4'b1111;
        expWdata = isByte ? {4{wdata[7:0]}} : wdata;
        if (isD) begin
            D_Req = 1'b1; D_We = we; D_Byte = isByte; D_Addr = addr; D_Wdata = wdata;
        end else begin
            If_Req = 1'b1; If_Addr = addr;
        end
        predict(isD, we, isByte, addr, wdata, e);
        sbQueue.push_back(e);
        @(negedge Clk);
        checkOutput("gnt", 32'({D_Gnt, If_Gnt}), isD ? 32'd2 : 32'd1);
        checkOutput("ramEn", 32'(Ram_En), misalign ? 32'd0 : 32'd1);
        checkOutput("ramWe", 32'(Ram_We), 32'(expWe));
        if (!misalign) checkOutput("ramAddr", 32'(Ram_Addr), 32'(addr[ADDR_W+1:2]));
        if (expWe != 4'b0000) checkOutput("ramWdata", Ram_Wdata, expWdata);
        D_Req  = 1'b0;
        If_Req = 1'b0;
    endtask

    task automatic waitResponse();
        exp_t e;
        int   lat;
        bit   seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            @(negedge Clk);
            lat++;
            seen = If_Valid || D_Valid;
        end
        checkOutput("respSeen", 32'(seen), 32'd1);
        checkOutput("sbPending", 32'(sbQueue.size()), 32'd1);
        if (seen && sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkOutput("validWho", 32'({D_Valid, If_Valid}), e.isD ? 32'd2 : 32'd1);
            checkOutput("latency", 32'(lat), 32'(e.lat));
            checkOutput("rdata", e.isD ? D_Rdata : If_Rdata, e.data);
            checkOutput("err", 32'(D_Err), 32'(e.err));
            if (e.isD) lastD = e.data;
            else       lastIf = e.data;
        end
    endtask

    initial begin
        exp_t       e;
        int         cyc;
        int         gntCyc;
        int         grants;
        int         validCount;
        logic [5:0] order;

        for (int i = 0; i < DEPTH; i++) modelMem[i] = memPattern(i);
        Reset_n = 1'b1;
        If_Req  = 1'b0; If_Addr = '0;
        D_Req   = 1'b0; D_We = 1'b0; D_Byte = 1'b0; D_Addr = '0; D_Wdata = '0;

        #1 Reset_n = 1'b0;
        #1;
        $display("[TB] reset checks");
        checkOutput("rstCtl", 32'({If_Gnt, D_Gnt, If_Valid, D_Valid, D_Err, Ram_En}), 32'd0);
        checkOutput("rstRamWe", 32'(Ram_We), 32'd0);
        checkOutput("rstRamAddr", 32'(Ram_Addr), 32'd0);
        checkOutput("rstRamWdata", Ram_Wdata, 32'd0);
        checkOutput("rstIfRdata", If_Rdata, 32'd0);
        checkOutput("rstDRdata", D_Rdata, 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        $display("[TB] fetch and word/byte data accesses");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h0);
        waitResponse();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_000B, 32'h0);
        waitResponse();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0013, 32'h0000_00AB);
        waitResponse();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0013, 32'h0);
        waitResponse();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678);
        waitResponse();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
        waitResponse();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0041, 32'h0);
        waitResponse();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_1040, 32'h0);
        waitResponse();

        $display("[TB] misaligned word accesses");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0006, 32'h0);
        waitResponse();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0042, 32'hFFFF_FFFF);
        waitResponse();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
        waitResponse();

        $display("[TB] contention with both requests held");
        D_Req = 1'b1; D_We = 1'b0; D_Byte = 1'b0; D_Addr = 32'h0000_0020;
        If_Req = 1'b1; If_Addr = 32'h0000_0008;
        cyc = 0; gntCyc = 0; grants = 0; order = '0;
        while ((grants < 6 || sbQueue.size() > 0) && cyc < 200) begin
            @(negedge Clk);
            cyc++;
            if (If_Gnt && D_Gnt) checkOutput("dualGnt", 32'd1, 32'd0);
            if (If_Valid && D_Valid) checkOutput("dualValid", 32'd1, 32'd0);
            if (If_Valid || D_Valid) begin
                checkOutput("cSbPending", 32'(sbQueue.size()), 32'd1);
                if (sbQueue.size() > 0) begin
                    e = sbQueue.pop_front();
                    checkOutput("cValidWho", 32'({D_Valid, If_Valid}), e.isD ? 32'd2 : 32'd1);
                    checkOutput("cLatency", 32'(cyc - gntCyc), 32'(e.lat));
                    checkOutput("cRdata", e.isD ? D_Rdata : If_Rdata, e.data);
                    checkOutput("cErr", 32'(D_Err), 32'(e.err));
                    if (e.isD) lastD = e.data;
                    else       lastIf = e.data;
                end
            end
            if ((If_Gnt || D_Gnt) && grants < 6) begin
                order  = {order[4:0], D_Gnt};
                gntCyc = cyc;
                grants++;
                if (D_Gnt) predict(1'b1, 1'b0, 1'b0, D_Addr, 32'h0, e);
                else       predict(1'b0, 1'b0, 1'b0, If_Addr, 32'h0, e);
                sbQueue.push_back(e);
                if (grants == 6) begin
                    D_Req  = 1'b0;
                    If_Req = 1'b0;
                end
            end
        end
        D_Req = 1'b0; If_Req = 1'b0;
        checkOutput("contentionDone", 32'(cyc < 200), 32'd1);
        checkOutput("grantOrder", 32'(order), 32'(6'b110110));

        $display("[TB] reset during store issue");
        D_Req = 1'b1; D_We = 1'b1; D_Byte = 1'b0; D_Addr = 32'h0000_0080; D_Wdata = 32'hDEAD_BEEF;
        @(negedge Clk);
        checkOutput("abortGnt", 32'(D_Gnt), 32'd1);
        checkOutput("abortWeBefore", 32'(Ram_We), 32'hF);
        Reset_n = 1'b0;
        D_Req   = 1'b0;
        #1;
        checkOutput("abortRamWe", 32'(Ram_We), 32'd0);
        checkOutput("abortRamEn", 32'(Ram_En), 32'd0);
        checkOutput("abortGntLow", 32'(D_Gnt), 32'd0);
        checkOutput("abortDRdata", D_Rdata, 32'd0);
        checkOutput("abortIfRdata", If_Rdata, 32'd0);
        lastD  = '0;
        lastIf = '0;
        validCount = 0;
        repeat (3) begin
            @(negedge Clk);
            if (If_Valid || D_Valid) validCount++;
        end
        Reset_n = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            if (If_Valid || D_Valid) validCount++;
        end
        checkOutput("abortNoValid", 32'(validCount), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h0);
        waitResponse();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0);
        waitResponse();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, RAM word-address width (RAM depth 2^ADDR_W words of 32 bits).
REQ-002 Parameter STARVE_MAX, default 2, maximum number of consecutive data grants while If_Req is pending.
REQ-003 Clk  in  1  single clock; all state changes on the rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 If_Req  in  1  instruction-fetch read request; held until If_Gnt.
REQ-006 If_Addr  in  32  fetch byte address.
REQ-007 If_Gnt  out  1  one-cycle pulse; the fetch has been issued to the RAM.
REQ-008 If_Valid  out  1  one-cycle pulse; If_Rdata holds the fetched word.
REQ-009 If_Rdata  out  32  fetched word; held until the next If_Valid.
REQ-010 D_Req  in  1  data-access request; held until D_Gnt.
REQ-011 D_We  in  1  1 = store, 0 = load.
REQ-012 D_Byte  in  1  1 = byte access (sb/lb), 0 = word access (sw/lw).
REQ-013 D_Addr  in  32  data byte address.
REQ-014 D_Wdata  in  32  store data; byte stores use D_Wdata[7:0].
REQ-015 D_Gnt  out  1  one-cycle pulse; the data access has been issued.
REQ-016 D_Valid  out  1  one-cycle pulse; load data is ready or the store is complete.
REQ-017 D_Rdata  out  32  load data; held until the next D_Valid.
REQ-018 D_Err  out  1  asserted together with D_Valid for a misaligned word access.
REQ-019 Ram_En  out  1  RAM access strobe.
REQ-020 Ram_We  out  4  per-byte write enables; bit i enables byte lane i (bits [8i+7:8i]).
REQ-021 Ram_Addr  out  ADDR_W  RAM word address.
REQ-022 Ram_Wdata  out  32  RAM write data.
REQ-023 Ram_Rdata  in  32  RAM read data; valid one cycle after Ram_En.

Function
REQ-024 The block SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-025 IDLE SHALL stay in IDLE when no request is present. On any request it SHALL latch the winner's address, We, Byte and Wdata, then go to ISSUE with the winner's Gnt high for the ISSUE cycle.
REQ-026 ISSUE SHALL drive Ram_En=1 and Ram_Addr = latched addr[ADDR_W+1:2]; upper address bits SHALL be ignored (wrap-around).
REQ-027 Word store: Ram_We=4'b1111 and Ram_Wdata=Wdata.
REQ-028 Byte store: Ram_We is one-hot on addr[1:0], and Ram_Wdata is Wdata[7:0] replicated into all four lanes.
REQ-029 ISSUE SHALL go to RESP for stores and to WAIT for loads.
REQ-030 WAIT SHALL capture Ram_Rdata.
REQ-031 Byte loads SHALL select the lane given by addr[1:0] and zero-extend it (24 leading zeros).
REQ-032 RESP SHALL pulse the winner's Valid for one cycle, update its Rdata (loads only) and return to IDLE.
REQ-033 Latency SHALL be: load Valid 3 cycles after the sampling edge; store Valid 2 cycles after the sampling edge.
REQ-034 At most one access SHALL be outstanding; requests are sampled only in IDLE.
REQ-035 A request dropped before its Gnt SHALL cause no access.
REQ-036 Arbitration when both If_Req and D_Req are present: data wins, unless the starvation count equals STARVE_MAX, in which case fetch wins.
REQ-037 The starvation count SHALL increment on each data grant made while If_Req=1.
REQ-038 The starvation count SHALL clear on any fetch grant, and on any arbitration where If_Req=0.
REQ-039 A word data access with D_Addr[1:0]≠0 SHALL skip the RAM: no Ram_En and Ram_We=0.
REQ-040 For that misaligned access the block SHALL go directly from ISSUE to RESP, assert D_Err with D_Valid, and leave D_Rdata unchanged.
REQ-041 The fetch path SHALL ignore If_Addr[1:0].
REQ-042 Ram_We SHALL be nonzero only in ISSUE.
REQ-043 Gnt/Valid SHALL never be asserted to both requesters in the same cycle.

Reset
REQ-044 While Reset_n=0, the block SHALL immediately be in state IDLE, and every output (Gnt, Valid, Err, Ram_En, Ram_We, Ram_Addr, Ram_Wdata, If_Rdata, D_Rdata) and the starvation count SHALL be 0.
REQ-045 A reset asserted during ISSUE, WAIT or RESP SHALL abort the access: no Valid is issued, and Ram_We drops to 0 without waiting for a clock edge.
REQ-046 After Reset_n rises, the first request sampled SHALL be arbitrated normally.

Verification
REQ-047 Fetch: If_Req=1, If_Addr=0x0000_0008 -> If_Gnt next cycle, Ram_Addr=2, and If_Valid 3 cycles after sampling with If_Rdata = RAM word 2.
REQ-048 Store then load: sb D_Addr=0x0000_0013, D_Wdata=0xAB -> Ram_We=4'b1000, Ram_Addr=4; then lb of the same address -> D_Rdata=0x0000_00AB.
REQ-049 Contention: If_Req and D_Req held continuously, STARVE_MAX=2 -> grant order D, D, I, D, D, I.
REQ-050 Misaligned: lw D_Addr=0x0000_0006 -> D_Valid=1, D_Err=1, no Ram_En, and D_Rdata unchanged.
REQ-051 Reset mid-access: Reset_n=0 during ISSUE of an sw -> Ram_We=0 immediately and no D_Valid; after release, the next If_Req is served normally.
